// File: rtl/nibble_pkg.sv
`default_nettype none
// +---------------------------------------------------------------+
// | nibble_pkg : shared types and helpers for nibble_packer       |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
package nibble_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      STALL = 1'b1
   } state_t;

   function automatic int clog2(input int n);
      int res;
      res = 0;
      while ((1 << res) < n) res++;
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_packer.sv
`default_nettype none
// +---------------------------------------------------------------+
// | nibble_packer : packs NIBBLES nibbles into one valid/ready     |
// | word; optional NIBBLE_PACKER_PARITY_EN adds out_par. Rev 1.0   |
// +---------------------------------------------------------------+
module nibble_packer
   import nibble_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                       clk,
   input  logic                       r,
   input  logic                       in_valid,
   input  logic [NIB_W-1:0]           in_d,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [NIBBLES*NIB_W-1:0]   out_data,
   input  logic                       out_ready,
`ifdef NIBBLE_PACKER_PARITY_EN
   output logic                       out_par,
`endif
   output logic                       ovf
);

   localparam int W  = NIBBLES * NIB_W;
   localparam int CW = clog2(NIBBLES);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    asm_word;
   logic [W-1:0]    asm_nxt;
   logic [W-1:0]    load_val;
   logic            accept;
   logic            last;
   logic            reg_free;
   logic            load_new;
   logic            load_drain;

   assign in_ready   = (state == FILL);
   assign accept     = in_valid && in_ready;
   assign last       = (cnt == CW'(NIBBLES - 1));
   assign reg_free   = !out_valid || out_ready;
   assign load_new   = accept && last && reg_free;
   assign load_drain = (state == STALL) && out_ready;

   always_comb begin
      asm_nxt = asm_word;
      asm_nxt[NIB_W*int'(cnt) +: NIB_W] = in_d;
      load_val = load_drain ? asm_word : asm_nxt;
   end

   always_ff @(posedge clk) begin
      if (r) begin
         state     <= FILL;
         cnt       <= '0;
         asm_word  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         ovf       <= 1'b0;
      end else begin
         if (in_valid && !in_ready) ovf <= 1'b1;
         case (state)
            FILL: begin
               if (accept) asm_word <= asm_nxt;
               if (accept && last) begin
                  cnt <= '0;
                  if (reg_free) begin
                     out_data  <= asm_nxt;
                     out_valid <= 1'b1;
                  end else begin
                     state <= STALL;
                  end
               end else begin
                  if (accept) cnt <= cnt + CW'(1);
                  if (out_valid && out_ready) out_valid <= 1'b0;
               end
            end
            STALL: begin
               // out_valid is necessarily high here, so draining keeps it high
               if (out_ready) begin
                  out_data <= asm_word;
                  state    <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

`ifdef NIBBLE_PACKER_PARITY_EN
   always_ff @(posedge clk) begin
      if (r) out_par <= 1'b0;
      else if (load_new || load_drain) out_par <= ^load_val;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_packer.sv
`default_nettype none
// +---------------------------------------------------------------+
// | tb_nibble_packer : random + directed scoreboard bench          |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
module tb_nibble_packer;

   localparam int NIBBLES = 4;
   localparam int W       = NIBBLES * 4;

   logic          clk = 1'b0;
   logic          r;
   logic          in_valid;
   logic [3:0]    in_d;
   logic          in_ready;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic          out_ready;
   logic          ovf;
`ifdef NIBBLE_PACKER_PARITY_EN
   logic          out_par;
`endif

   always #5 clk = ~clk;

   nibble_packer #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .r         (r),
      .in_valid  (in_valid),
      .in_d      (in_d),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
`ifdef NIBBLE_PACKER_PARITY_EN
      .out_par   (out_par),
`endif
      .ovf       (ovf)
   );

   int            total  = 0;
   int            passed = 0;
   logic [W-1:0]  exp_q[$];
   logic [3:0]    nib_q[$];
   int            pending = 0;
   bit            ovf_m   = 1'b0;
   bit            mon_en  = 1'b0;
   bit            m_rdy;
   bit            m_hs;
   logic [W-1:0]  m_word;
   logic [W-1:0]  m_exp;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: the packer holds at most two finished words
   // (output register plus one stalled word); nibbles beyond that are lost.
   always @(posedge clk) begin
      if (r) begin
         nib_q.delete();
         exp_q.delete();
         pending = 0;
         ovf_m   = 1'b0;
         mon_en  = 1'b1;
      end else if (mon_en) begin
         m_rdy = (pending < 2);
         m_hs  = (pending > 0) && out_ready;
         if (in_valid && !m_rdy) ovf_m = 1'b1;
         if (in_valid && m_rdy) begin
            nib_q.push_back(in_d);
            if (nib_q.size() == NIBBLES) begin
               m_word = '0;
               for (int i = 0; i < NIBBLES; i++) m_word[4*i +: 4] = nib_q[i];
               exp_q.push_back(m_word);
               nib_q.delete();
               pending++;
            end
         end
         if (m_hs) pending--;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("in_ready",  64'(in_ready),  64'(pending < 2));
         chk("out_valid", 64'(out_valid), 64'(pending > 0));
         chk("ovf",       64'(ovf),       64'(ovf_m));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL out_word: got %0h expected none (queue empty) at %0t", out_data, $time);
            end else begin
               m_exp = exp_q.pop_front();
               chk("out_data", 64'(out_data), 64'(m_exp));
`ifdef NIBBLE_PACKER_PARITY_EN
               chk("out_par", 64'(out_par), 64'(^m_exp));
`endif
            end
         end
      end
   end

   task automatic cyc(input logic iv, input logic [3:0] d, input logic ordy);
      in_valid  = iv;
      in_d      = d;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      r = 1'b1;
      cyc(1'b0, 4'h0, 1'b0);
      r = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data",  64'(out_data),  64'd0);
      chk("rst_ovf",       64'(ovf),       64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 12 && exp_q.size() > 0; i++) cyc(1'b0, 4'h0, 1'b1);
      cyc(1'b0, 4'h0, 1'b1);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      r = 1'b1; in_valid = 1'b0; in_d = 4'h0; out_ready = 1'b0;
      do_reset();

      // basic pack
      for (int i = 1; i <= 4; i++) cyc(1'b1, 4'(i), 1'b1);
      cyc(1'b0, 4'h0, 1'b1);
      drain();

      // gapped input: 5,_,6,_,_,7,8
      cyc(1'b1, 4'h5, 1'b1); cyc(1'b0, 4'hF, 1'b1);
      cyc(1'b1, 4'h6, 1'b1); cyc(1'b0, 4'hF, 1'b1); cyc(1'b0, 4'hF, 1'b1);
      cyc(1'b1, 4'h7, 1'b1); cyc(1'b1, 4'h8, 1'b1);
      drain();

      // backpressure, stall and overflow
      for (int i = 0; i < 8; i++) cyc(1'b1, 4'(i), 1'b0);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      cyc(1'b1, 4'h9, 1'b0);
      chk("stall_ovf", 64'(ovf), 64'd1);
      drain();

      // back-to-back streaming
      do_reset();
      for (int i = 0; i < 12; i++) cyc(1'b1, 4'(i), 1'b1);
      drain();

      // reset mid-operation
      cyc(1'b1, 4'hE, 1'b1); cyc(1'b1, 4'hF, 1'b1);
      do_reset();
      cyc(1'b1, 4'hA, 1'b1); cyc(1'b1, 4'hB, 1'b1);
      cyc(1'b1, 4'hC, 1'b1); cyc(1'b1, 4'hD, 1'b1);
      drain();

      // parity words 0x0001 and 0x0003
      cyc(1'b1, 4'h1, 1'b1); cyc(1'b1, 4'h0, 1'b1); cyc(1'b1, 4'h0, 1'b1); cyc(1'b1, 4'h0, 1'b1);
      cyc(1'b1, 4'h3, 1'b1); cyc(1'b1, 4'h0, 1'b1); cyc(1'b1, 4'h0, 1'b1); cyc(1'b1, 4'h0, 1'b1);
      drain();

      // randomized traffic with occasional resets
      for (int i = 0; i < 2000; i++) begin
         r = ($urandom_range(0, 249) == 0);
         cyc(($urandom_range(0, 9) < 7), 4'($urandom), 1'($urandom_range(0, 1)));
      end
      r = 1'b0;
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
